// File: rtl/fixed_vec_packer_if.sv
// ---------------------------------------------------------------------------
// fixed_vec_packer_if
//
// Bundles the element stream, the packed vector that feeds the adder tree,
// and the shadow-pipe status that goes alongside the tree output.
//
// Signals:
//   in_valid  - element present on in_data (producer -> packer)
//   in_ready  - packer can accept an element (packer -> producer)
//   in_data   - signed element value
//   in_last   - element closes the current group (qualified by in_valid)
//   flush     - force emission of a partially filled vector
//   vec_data  - unpacked LANES-wide vector to the tree
//   vec_valid - one-cycle pulse, vec_data updated this cycle
//   sum_valid - tree output holds the sum of a packed vector this cycle
//   sum_last  - that sum closes a group
//   sum_count - number of real (non-pad) lanes in that sum
//
// Modports:
//   master - producer / test side (drives the element stream)
//   slave  - the packer itself
// ---------------------------------------------------------------------------
interface fixed_vec_packer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 32
);
  localparam int CNT_W = $clog2(LANES) + 1;

  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] in_data;
  logic                         in_last;
  logic                         flush;
  logic signed [DATA_WIDTH-1:0] vec_data [0:LANES-1];
  logic                         vec_valid;
  logic                         sum_valid;
  logic                         sum_last;
  logic [CNT_W-1:0]             sum_count;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    output flush,
    input  in_ready,
    input  vec_data,
    input  vec_valid,
    input  sum_valid,
    input  sum_last,
    input  sum_count
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    input  flush,
    output in_ready,
    output vec_data,
    output vec_valid,
    output sum_valid,
    output sum_last,
    output sum_count
  );
endinterface

// File: rtl/fixed_vec_packer.sv
// ---------------------------------------------------------------------------
// fixed_vec_packer
//
// Producer-side front end for the LANES-input pipelined adder tree. Serial
// signed elements arrive over a valid/ready handshake and are packed into a
// LANES-wide vector; short groups are zero-padded. A {valid, last, count}
// shadow pipe, TREE_LATENCY deep, marks the cycle on which the tree output
// holds the sum of each emitted vector.
//
// Ports:
//   clk   - clock, all state updates on posedge
//   rst_n - asynchronous, active-low reset
//   bus   - fixed_vec_packer_if.slave (element stream in, vector and sum
//           status out)
//
// Parameters:
//   DATA_WIDTH   - width of each signed element / vector lane
//   LANES        - vector width, power of two >= 2, equals tree fan-in
//   TREE_LATENCY - cycles from a vector update to the tree sum register
// ---------------------------------------------------------------------------
module fixed_vec_packer #(
  parameter int DATA_WIDTH   = 32,
  parameter int LANES        = 32,
  parameter int TREE_LATENCY = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  fixed_vec_packer_if.slave   bus
);

  localparam int CW = $clog2(LANES);
  localparam int NW = CW + 1;

  // Fill pointer and staging buffer for the group being assembled
  logic [CW-1:0]                cnt;
  logic signed [DATA_WIDTH-1:0] staging [0:LANES-1];

  // Per-cycle decode
  logic                         beat;
  logic                         emit;
  logic [NW-1:0]                fill;
  logic signed [DATA_WIDTH-1:0] next_vec [0:LANES-1];

  // Side information that travels with vec_valid into the shadow pipe
  logic                         vec_last;
  logic [NW-1:0]                vec_count;

  // Shadow pipe stages; stage k holds the entry that entered k+1 cycles ago
  logic [TREE_LATENCY-1:0]      pipe_valid;
  logic [TREE_LATENCY-1:0]      pipe_last;
  logic [NW-1:0]                pipe_count [0:TREE_LATENCY-1];

  // Handshake and emit decode. fill is the group length including the beat
  // on this cycle, which is the number of real lanes if we emit now.
  always_comb begin
    beat = bus.in_valid && bus.in_ready;
    fill = beat ? ({1'b0, cnt} + NW'(1)) : {1'b0, cnt};
    if (beat) begin
      emit = (cnt == CW'(LANES - 1)) || bus.in_last || bus.flush;
    end else begin
      emit = bus.flush && (cnt != '0);
    end
  end

  // Next vector contents: the closing beat is forwarded straight into its
  // lane, so the vector does not need an extra cycle through the staging
  // buffer. Lanes at or above the fill level are forced to zero padding.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      next_vec[i] = '0;
      if (NW'(i) < fill) begin
        if (beat && (CW'(i) == cnt)) begin
          next_vec[i] = bus.in_data;
        end else begin
          next_vec[i] = staging[i];
        end
      end
    end
  end

  // in_ready is held low through reset and rises on the first edge after
  // release; the tree never stalls, so it stays high from then on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.in_ready <= 1'b0;
    end else begin
      bus.in_ready <= 1'b1;
    end
  end

  // Staging buffer and fill pointer. Emission clears everything so the
  // next group can start on the very next cycle without a bubble, and so
  // that unwritten lanes are always zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      for (int i = 0; i < LANES; i++) begin
        staging[i] <= '0;
      end
    end else if (emit) begin
      cnt <= '0;
      for (int i = 0; i < LANES; i++) begin
        staging[i] <= '0;
      end
    end else if (beat) begin
      cnt          <= cnt + CW'(1);
      staging[cnt] <= bus.in_data;
    end
  end

  // Vector register towards the tree. vec_data is held between emissions;
  // the tree re-summing it is harmless because only the shadow pipe marks
  // meaningful sums. last/count are zero outside the emission pulse so the
  // shadow pipe carries clean zeros between entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.vec_valid <= 1'b0;
      vec_last      <= 1'b0;
      vec_count     <= '0;
      for (int i = 0; i < LANES; i++) begin
        bus.vec_data[i] <= '0;
      end
    end else begin
      bus.vec_valid <= emit;
      vec_last      <= emit && beat && bus.in_last;
      vec_count     <= emit ? fill : '0;
      if (emit) begin
        for (int i = 0; i < LANES; i++) begin
          bus.vec_data[i] <= next_vec[i];
        end
      end
    end
  end

  // Shadow pipe. An entry entering with vec_valid at cycle T reaches the
  // last stage at T+TREE_LATENCY, the same cycle the tree output register
  // holds that vector's sum. Every stage shifts every cycle, so back-to-back
  // emissions stay distinct.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_valid <= '0;
      pipe_last  <= '0;
      for (int i = 0; i < TREE_LATENCY; i++) begin
        pipe_count[i] <= '0;
      end
    end else begin
      pipe_valid[0] <= bus.vec_valid;
      pipe_last[0]  <= vec_last;
      pipe_count[0] <= vec_count;
      for (int i = 1; i < TREE_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_last[i]  <= pipe_last[i-1];
        pipe_count[i] <= pipe_count[i-1];
      end
    end
  end

  assign bus.sum_valid = pipe_valid[TREE_LATENCY-1];
  assign bus.sum_last  = pipe_last[TREE_LATENCY-1];
  assign bus.sum_count = pipe_count[TREE_LATENCY-1];

endmodule

// File: tb/tb_fixed_vec_packer.sv
// ---------------------------------------------------------------------------
// tb_fixed_vec_packer
//
// Directed bench for fixed_vec_packer. Inputs are driven one cycle at a time
// #1 after the rising edge and outputs are sampled at the same point. The
// "tree output" is taken as the sum of the lanes the packer presents while
// sum_valid is high (vec_data is held between emissions).
// ---------------------------------------------------------------------------
module tb_fixed_vec_packer;

  localparam int DW    = 32;
  localparam int LANES = 32;
  localparam int LAT   = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Emission / sum event log filled by the monitor
  int     vq [$];
  int     sq [$];
  longint vs [$];
  longint ss [$];

  fixed_vec_packer_if #(.DATA_WIDTH(DW), .LANES(LANES)) bus ();

  fixed_vec_packer #(
    .DATA_WIDTH   (DW),
    .LANES        (LANES),
    .TREE_LATENCY (LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint lane_sum();
    longint s;
    s = 0;
    for (int i = 0; i < LANES; i++) begin
      s += longint'(bus.vec_data[i]);
    end
    return s;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.vec_valid) begin
        vq.push_back(cyc);
        vs.push_back(lane_sum());
      end
      if (bus.sum_valid) begin
        sq.push_back(cyc);
        ss.push_back(lane_sum());
      end
    end
  end

  task automatic checkOutput(input string tag,
                             input logic signed [63:0] obs,
                             input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
  endtask

  task automatic applyStimulus(input logic v, input logic signed [DW-1:0] d,
                               input logic l, input logic f);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_last  = l;
    bus.flush    = f;
    @(posedge clk);
    #1;
  endtask

  task automatic checkZeroLanes(input string tag, input int from);
    for (int i = from; i < LANES; i++) begin
      checkOutput(tag, bus.vec_data[i], 0);
    end
  endtask

  // Called on the cycle vec_valid is expected high; idles and checks that
  // the sum marker appears exactly LAT cycles later for one cycle.
  task automatic waitSum(input string tag, input logic exp_last,
                         input int exp_count, input longint exp_sum);
    for (int k = 1; k < LAT; k++) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      checkOutput({tag, "_vec_pulse"}, bus.vec_valid, 0);
      checkOutput({tag, "_sum_early"}, bus.sum_valid, 0);
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput({tag, "_sum_valid"}, bus.sum_valid, 1);
    checkOutput({tag, "_sum_last"},  bus.sum_last,  exp_last);
    checkOutput({tag, "_sum_count"}, bus.sum_count, exp_count);
    checkOutput({tag, "_tree_sum"},  lane_sum(),    exp_sum);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput({tag, "_sum_pulse"}, bus.sum_valid, 0);
  endtask

  int t2 [5] = '{-3, 7, -1, 2, 10};

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    bus.flush    = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready",  bus.in_ready,  0);
    checkOutput("rst_vec_valid", bus.vec_valid, 0);
    checkOutput("rst_sum_valid", bus.sum_valid, 0);
    checkOutput("rst_sum_last",  bus.sum_last,  0);
    checkOutput("rst_sum_count", bus.sum_count, 0);
    checkZeroLanes("rst_lane", 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("ready_at_release", bus.in_ready, 0);
    @(posedge clk);
    #1;
    checkOutput("ready_after_edge", bus.in_ready, 1);

    // Test 1: 1..32 with last on beat 32
    $display("[TB] full group 1..32");
    for (int i = 1; i <= 32; i++) begin
      applyStimulus(1'b1, DW'(i), (i == 32), 1'b0);
    end
    checkOutput("t1_vec_valid", bus.vec_valid, 1);
    for (int i = 0; i < LANES; i++) begin
      checkOutput("t1_lane", bus.vec_data[i], i + 1);
    end
    waitSum("t1", 1'b1, 32, 528);

    // Test 2: short group zero-padded
    $display("[TB] short group with last");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, DW'(t2[i]), (i == 4), 1'b0);
    end
    checkOutput("t2_vec_valid", bus.vec_valid, 1);
    for (int i = 0; i < 5; i++) begin
      checkOutput("t2_lane", bus.vec_data[i], t2[i]);
    end
    checkZeroLanes("t2_pad", 5);
    waitSum("t2", 1'b1, 5, 15);

    // Test 3: flush without a beat, then flush on an empty buffer
    $display("[TB] flush behaviour");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, DW'(4), 1'b0, 1'b0);
    end
    checkOutput("t3_no_early_emit", bus.vec_valid, 0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("t3_vec_valid", bus.vec_valid, 1);
    for (int i = 0; i < 3; i++) begin
      checkOutput("t3_lane", bus.vec_data[i], 4);
    end
    checkZeroLanes("t3_pad", 3);
    waitSum("t3", 1'b0, 3, 12);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("t3_empty_flush", bus.vec_valid, 0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("t3_empty_flush_next", bus.vec_valid, 0);

    // Test 4: 64 back-to-back beats of -1
    $display("[TB] back-to-back full vectors");
    vq.delete(); sq.delete(); vs.delete(); ss.delete();
    for (int i = 0; i < 64; i++) begin
      checkOutput("t4_ready", bus.in_ready, 1);
      applyStimulus(1'b1, -1, 1'b0, 1'b0);
    end
    repeat (LAT + 3) applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("t4_vec_pulses", vq.size(), 2);
    checkOutput("t4_sum_pulses", sq.size(), 2);
    if (vq.size() == 2 && sq.size() == 2) begin
      checkOutput("t4_vec_spacing", vq[1] - vq[0], 32);
      checkOutput("t4_sum_spacing", sq[1] - sq[0], 32);
      checkOutput("t4_latency",     sq[0] - vq[0], LAT);
      checkOutput("t4_sum0",        ss[0], -32);
      checkOutput("t4_sum1",        ss[1], -32);
    end

    // Test 5: reset mid-group with a vector 2 cycles into the shadow pipe
    $display("[TB] reset mid-group and mid-pipe");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, DW'(3), (i == 7), 1'b0);
    end
    checkOutput("t5_vec_valid", bus.vec_valid, 1);
    applyStimulus(1'b1, DW'(9), 1'b0, 1'b0);
    applyStimulus(1'b1, DW'(9), 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_ready",     bus.in_ready,  0);
    checkOutput("t5_rst_vec_valid", bus.vec_valid, 0);
    checkOutput("t5_rst_sum_valid", bus.sum_valid, 0);
    checkOutput("t5_rst_sum_count", bus.sum_count, 0);
    checkZeroLanes("t5_rst_lane", 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("t5_ready_at_release", bus.in_ready, 0);
    @(posedge clk);
    #1;
    checkOutput("t5_ready_after_edge", bus.in_ready, 1);
    for (int k = 0; k < LAT + 3; k++) begin
      checkOutput("t5_no_sum", bus.sum_valid, 0);
      checkOutput("t5_no_vec", bus.vec_valid, 0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
    end
    for (int i = 1; i <= 32; i++) begin
      applyStimulus(1'b1, DW'(i), (i == 32), 1'b0);
    end
    checkOutput("t5_vec_valid_fresh", bus.vec_valid, 1);
    checkOutput("t5_lane0", bus.vec_data[0], 1);
    checkOutput("t5_lane31", bus.vec_data[31], 32);
    waitSum("t5", 1'b1, 32, 528);

    // Test 6: extreme negative values
    $display("[TB] minimum-value lanes");
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b1, 32'sh8000_0000, (i == 31), 1'b0);
    end
    checkOutput("t6_vec_valid", bus.vec_valid, 1);
    for (int i = 0; i < LANES; i++) begin
      checkOutput("t6_lane", bus.vec_data[i], 32'sh8000_0000);
    end
    waitSum("t6", 1'b1, 32, -64'sd68719476736);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fixed_vec_packer.md
Name: fixed_vec_packer

Overview:
Producer-side front end for the 32-lane pipelined fixed-point adder tree. Accepts a serial stream of signed elements over a valid/ready handshake and packs them into a LANES-wide vector, zero-padding short groups. Drives the tree's unpacked vector input. Runs a valid/last/count shadow pipeline matched to the tree latency, so downstream logic knows on which cycle the tree output is a meaningful sum.

Parameters:
DATA_WIDTH, 32, width of each signed element and each vector lane.
LANES, 32, vector width; must be a power of two ≥ 2; equals the tree fan-in.
TREE_LATENCY, 5, cycles from a vector register update to the tree output register holding its sum (log2(LANES)).

Ports:
clk  input  1  clock; all state updates on posedge.
rst_n  input  1  reset; asynchronous assert, active-low.
in_valid  input  1  element present on in_data.
in_ready  output  1  packer can accept an element this cycle.
in_data  input  DATA_WIDTH (signed)  element value.
in_last  input  1  element closes the current group; qualified by in_valid.
flush  input  1  force emission of a partially filled vector.
vec_data  output  DATA_WIDTH (signed) x [0:LANES-1] unpacked  vector to the tree.
vec_valid  output  1  one-cycle pulse; vec_data updated this cycle.
sum_valid  output  1  tree output holds the sum of a packed vector this cycle.
sum_last  output  1  that sum closes a group.
sum_count  output  $clog2(LANES)+1  number of real (non-pad) lanes in that sum.

Behaviour:
- Reset (rst_n=0, async): cnt=0, staging buffer=0, vec_data all lanes 0, vec_valid=0, in_ready=0, sum_valid/sum_last/sum_count=0, shadow pipe cleared.
- in_ready is registered. It is 0 during reset and on the first clk edge after rst_n rises, then 1 continuously. The tree never stalls, so the packer applies no backpressure after that.
- Beat = in_valid && in_ready. A beat writes in_data into staging lane cnt and increments cnt.
- Emit condition on a cycle with a beat: cnt==LANES-1 OR in_last OR flush.
- Emit condition on a cycle with no beat: flush && cnt>0. flush with cnt==0 and no beat is ignored.
- On emit, at the next edge:
  - vec_data[i] = staging lane i for i below the fill level (current beat included); all higher lanes = 0.
  - vec_valid=1 for exactly one cycle.
  - Internal count = fill level (1..LANES); internal last = in_last of the closing beat (0 if closed by flush alone or by a full vector without in_last).
  - cnt returns to 0 and the staging buffer clears to 0.
- A new group may start on the cycle immediately after emission. Back-to-back full vectors every LANES cycles are supported with no bubble.
- vec_data holds its value between emissions. The tree re-summing a held vector is harmless; only the shadow pipe marks valid sums.
- in_last on a full vector (cnt==LANES-1) yields one emission with last=1, not an extra empty vector.
- Shadow pipe: {valid, last, count} shift register, TREE_LATENCY deep, entered with vec_valid. If vec_valid is high at cycle T, sum_valid/sum_last/sum_count are asserted at cycle T+TREE_LATENCY for one cycle. Consecutive emissions stay distinct.
- Width: no arithmetic in the packer; lanes are passed bit-exact and sign preserved. The tree widens the sum to DATA_WIDTH+log2(LANES).
- Reset mid-group or mid-pipe: partial group discarded, no emission, all in-flight shadow entries dropped; sum_valid stays 0 until new vectors traverse the pipe.

Test Plan:
- 32 beats with values 1..32, in_last on beat 32 -> vec_valid one cycle after beat 32; vec_data[i]=i+1. Five cycles later sum_valid=1, sum_last=1, sum_count=32, and the tree output is 528.
- 5 beats {-3,7,-1,2,10} with in_last on the 5th -> vec lanes 0..4 match, lanes 5..31 = 0, sum_count=5, tree output 15, sum_last=1.
- 3 beats {4,4,4}, then flush with in_valid=0 -> one emission, sum_count=3, sum_last=0, tree output 12. A later flush with cnt==0 produces no vec_valid.
- 64 consecutive beats of value -1 with no idle cycles -> two vec_valid pulses exactly 32 cycles apart, two sum_valid pulses 32 apart, each with tree output -32. in_ready stays 1 throughout.
- Assert rst_n=0 after 10 beats and while one emitted vector is 2 cycles into the shadow pipe -> all outputs 0 immediately, no sum_valid afterwards. in_ready=0 until one edge after release. A fresh 32-beat group then sums correctly.
- Extreme values: 32 beats of -2^(DATA_WIDTH-1) -> lanes carry the bit-exact minimum value, and the tree output is -2^(DATA_WIDTH+4) with no overflow.
